// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and constants for the A2D SPI responder.
package a2d_spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int RES_W      = 12;
   localparam int NUM_CH     = 8;
   localparam int CH_W       = $clog2(NUM_CH);
   localparam int CMD_CH_MSB = 13;
   localparam int CMD_CH_LSB = 11;
   // bit counter must hold FRAME_BITS+1 so long frames are detectable
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } resp_state_t;

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI pin bundle between the A2D interface master and the responder.
interface a2d_spi_resp_if;

   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/a2d_spi_resp_sync.sv
// Synchronizer plus history flop for one asynchronous SPI pin; yields level and edge pulses.
module spi_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   // shift the pin through the sync chain; history holds the previous synced level
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // reset to the idle-high level so no false edge appears after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating the 8-channel 12-bit A2D, with one-frame channel pipelining.
//
// state | meaning
// IDLE  | SS_n high, MISO driven low, waiting for SS_n fall
// SHIFT | frame in progress: shift MOSI in on SCLK rise, MISO out on SCLK fall
module a2d_spi_resp
   import a2d_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   a2d_spi_resp_if.slave           spi,
   input  logic [NUM_CH*RES_W-1:0] ch_data,
   output logic [CH_W-1:0]         chnnl,
   output logic                    frm_done,
   output logic                    frm_err
);

   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_sync;

   resp_state_t           state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
   logic [FRAME_BITS-1:0] rx_shft_q, rx_shft_d;
   logic [CH_W-1:0]       chnnl_q, chnnl_d;
   logic                  miso_q, miso_d;
   logic                  frm_done_q, frm_done_d;
   logic                  frm_err_q, frm_err_d;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
      .clk(clk), .rst(rst), .din(spi.SS_n),
      .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
   );

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(spi.SCLK),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
      .clk(clk), .rst(rst), .din(spi.MOSI),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
   );

   // only edges of SS_n/SCLK and the level of MOSI are consumed
   assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state: a frame spans SS_n fall to SS_n rise
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ss_fall) state_d = SHIFT;
         SHIFT:   if (ss_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath and outputs; ss_rise takes priority over any SCLK edge in the same clk
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      tx_shft_d  = tx_shft_q;
      rx_shft_d  = rx_shft_q;
      chnnl_d    = chnnl_q;
      frm_done_d = 1'b0;
      frm_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               // snapshot the previously addressed channel for the whole frame
               tx_shft_d = {{(FRAME_BITS-RES_W){1'b0}},
                            ch_data[int'(chnnl_q)*RES_W +: RES_W]};
               bit_cnt_d = '0;
               rx_shft_d = '0;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
                  chnnl_d    = rx_shft_q[CMD_CH_MSB:CMD_CH_LSB];
                  frm_done_d = 1'b1;
               end else begin
                  frm_err_d  = 1'b1;
               end
            end else if (sclk_rise) begin
               rx_shft_d = {rx_shft_q[FRAME_BITS-2:0], mosi_lvl};
               if (bit_cnt_q != CNT_W'(FRAME_BITS + 1))
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else if (sclk_fall && (bit_cnt_q != '0)) begin
               // the master's leading SCLK fall must not consume the MSB
               tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
            end
         end
         default: ;
      endcase
      miso_d = (state_d == SHIFT) ? tx_shft_d[FRAME_BITS-1] : 1'b0;
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         tx_shft_q  <= '0;
         rx_shft_q  <= '0;
         chnnl_q    <= '0;
         miso_q     <= 1'b0;
         frm_done_q <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         tx_shft_q  <= tx_shft_d;
         rx_shft_q  <= rx_shft_d;
         chnnl_q    <= chnnl_d;
         miso_q     <= miso_d;
         frm_done_q <= frm_done_d;
         frm_err_q  <= frm_err_d;
      end
   end

   assign spi.MISO = miso_q;
   assign chnnl    = chnnl_q;
   assign frm_done = frm_done_q;
   assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: SPI master at clk/32, SCLK idle high.
module tb_a2d_spi_resp;
   import a2d_spi_pkg::*;

   logic                    clk;
   logic                    rst;
   logic [NUM_CH*RES_W-1:0] ch_data;
   logic [CH_W-1:0]         chnnl;
   logic                    frm_done;
   logic                    frm_err;

   a2d_spi_resp_if spi_if ();

   a2d_spi_resp dut (
      .clk(clk), .rst(rst), .spi(spi_if),
      .ch_data(ch_data), .chnnl(chnnl),
      .frm_done(frm_done), .frm_err(frm_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   // count pulse-high cycles; a proper pulse adds exactly one per frame
   always @(posedge clk) begin
      if (frm_done) done_cnt++;
      if (frm_err)  err_cnt++;
      if (frm_done && frm_err) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [11:0] v);
      ch_data[k*RES_W +: RES_W] = v;
   endtask

   // full or short frame; mod_bit >= 0 rewrites ch0 data while that bit is being shifted
   task automatic run_frame(input logic [2:0] ch, input int nbits, input int mod_bit,
                            input logic [11:0] mod_val, input int gap,
                            output logic [15:0] word);
      logic [15:0] cmd;
      cmd  = {2'b00, ch, 11'h000};
      word = '0;
      spi_if.SS_n = 1'b0;
      tick(16);
      for (int i = 0; i < nbits; i++) begin
         spi_if.SCLK = 1'b0;
         spi_if.MOSI = cmd[15-i];
         if (i == mod_bit) set_ch(0, mod_val);
         tick(16);
         word[15-i] = spi_if.MISO;
         spi_if.SCLK = 1'b1;
         tick(16);
      end
      spi_if.SS_n = 1'b1;
      tick(gap);
   endtask

   logic [15:0] w;
   int          d0, e0;
   logic [11:0] vals [8];
   logic [2:0]  seq  [9];
   logic [2:0]  prev;

   initial begin
      rst         = 1'b1;
      ch_data     = '0;
      spi_if.SS_n = 1'b1;
      spi_if.SCLK = 1'b1;
      spi_if.MOSI = 1'b0;
      set_ch(0, 12'hABC);
      tick(4);
      rst = 1'b0;
      tick(8);

      // 1: reset values and first frame returns channel 0
      chk("rst_miso", spi_if.MISO, 0);
      chk("rst_chnnl", chnnl, 0);
      chk("rst_done", done_cnt, 0);
      chk("rst_err", err_cnt, 0);
      run_frame(3'd0, 16, -1, 12'h000, 20, w);
      chk("t1_word", w, 16'h0ABC);
      chk("t1_done", done_cnt, 1);
      chk("t1_err", err_cnt, 0);
      chk("t1_chnnl", chnnl, 0);
      chk("t1_miso_idle", spi_if.MISO, 0);

      // 2: pipelined channel selection
      set_ch(5, 12'h123);
      set_ch(0, 12'h456);
      run_frame(3'd5, 16, -1, 12'h000, 20, w);
      chk("t2a_word", w, 16'h0456);
      chk("t2a_chnnl", chnnl, 5);
      run_frame(3'd0, 16, -1, 12'h000, 20, w);
      chk("t2b_word", w, 16'h0123);
      chk("t2b_chnnl", chnnl, 0);
      chk("t2_done", done_cnt, 3);

      // 3: short frame flags error and keeps channel
      d0 = done_cnt; e0 = err_cnt;
      run_frame(3'd3, 9, -1, 12'h000, 20, w);
      chk("t3_err", err_cnt - e0, 1);
      chk("t3_done", done_cnt - d0, 0);
      chk("t3_chnnl", chnnl, 0);
      run_frame(3'd0, 16, -1, 12'h000, 20, w);
      chk("t3_next_word", w, 16'h0456);

      // 4: data snapshot at SS_n fall
      set_ch(0, 12'h111);
      run_frame(3'd0, 16, 5, 12'hFFF, 20, w);
      chk("t4a_word", w, 16'h0111);
      run_frame(3'd0, 16, -1, 12'h000, 20, w);
      chk("t4b_word", w, 16'h0FFF);

      // 5: reset mid-frame
      set_ch(2, 12'h222);
      run_frame(3'd2, 16, -1, 12'h000, 20, w);
      chk("t5_pre_chnnl", chnnl, 2);
      d0 = done_cnt; e0 = err_cnt;
      spi_if.SS_n = 1'b0;
      tick(16);
      for (int i = 0; i < 7; i++) begin
         spi_if.SCLK = 1'b0;
         spi_if.MOSI = (i == 3);
         tick(16);
         spi_if.SCLK = 1'b1;
         tick(16);
      end
      rst = 1'b1;
      tick(2);
      chk("t5_rst_miso", spi_if.MISO, 0);
      chk("t5_rst_chnnl", chnnl, 0);
      spi_if.SS_n = 1'b1;
      tick(8);
      rst = 1'b0;
      tick(12);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_no_err", err_cnt - e0, 0);
      run_frame(3'd0, 16, -1, 12'h000, 20, w);
      chk("t5_next_word", w, 16'h0FFF);
      chk("t5_next_chnnl", chnnl, 0);

      // 6: all channels, back-to-back with a 2-SCLK gap
      vals = '{12'h5A1, 12'h3C2, 12'h7E3, 12'h0F4, 12'hC35, 12'h966, 12'hE87, 12'h2D8};
      seq  = '{3'd3, 3'd7, 3'd1, 3'd6, 3'd0, 3'd5, 3'd2, 3'd4, 3'd0};
      for (int k = 0; k < 8; k++) set_ch(k, vals[k]);
      prev = 3'd0;
      d0 = done_cnt; e0 = err_cnt;
      for (int f = 0; f < 9; f++) begin
         run_frame(seq[f], 16, -1, 12'h000, 64, w);
         chk($sformatf("t6_word%0d", f), w, {4'h0, vals[prev]});
         chk($sformatf("t6_chnnl%0d", f), chnnl, seq[f]);
         prev = seq[f];
      end
      chk("t6_done", done_cnt - d0, 9);
      chk("t6_err", err_cnt - e0, 0);
      chk("never_both", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
